// File: rtl/tl_rx_cpl_write_control.sv
// Producer side of the RX completion buffer: realigns payload into 8-DW data entries and commits the header last.
// Optional: define CPL_LEN_CHECK_EN to flag Length/EOP mismatches on o_malformed (tied 0 otherwise).
module tl_rx_cpl_write_control #(
    parameter int DATA_WIDTH     = 256,
    parameter int HDR_WIDTH      = 96,
    parameter int PAYLOAD_LENGTH = 10,
    parameter int FREE_CNT_WIDTH = 8
) (
    input  logic                      i_clk,
    input  logic                      i_n_rst,
    input  logic                      i_tlp_valid,
    input  logic                      i_tlp_sop,
    input  logic                      i_tlp_eop,
    input  logic [DATA_WIDTH-1:0]     i_tlp_data,
    output logic                      o_tlp_ready,
    input  logic                      i_hdr_full,
    input  logic [FREE_CNT_WIDTH-1:0] i_data_free_entries,
    output logic                      o_hdr_wr_en,
    output logic [HDR_WIDTH-1:0]      o_hdr_wr_data,
    output logic                      o_data_wr_en,
    output logic [DATA_WIDTH-1:0]     o_data_wr_data,
    output logic                      o_malformed
);
    localparam int NUM_DW   = DATA_WIDTH / 32;
    localparam int CARRY_DW = NUM_DW - HDR_WIDTH / 32;
    localparam int CARRY_W  = CARRY_DW * 32;
    localparam int LW       = PAYLOAD_LENGTH + 1;
    localparam int CCW      = $clog2(CARRY_DW + 1);

    typedef enum logic [1:0] {IDLE, DATA, FLUSH, COMMIT} state_t;

    state_t                    state, state_nxt;
    logic [HDR_WIDTH-1:0]      hdr_reg;
    logic [CARRY_W-1:0]        carry_reg;
    logic [LW-1:0]             rem_dw;
    logic [CCW-1:0]            carry_cnt;

    logic                      has_data;
    logic [PAYLOAD_LENGTH-1:0] len_fld;
    logic [LW-1:0]             l_eff;
    logic [LW-1:0]             rem_dec;
    logic [LW:0]               need;
    logic                      sop_take;
    logic                      beat_take;

    assign has_data = i_tlp_data[30];
    assign len_fld  = i_tlp_data[PAYLOAD_LENGTH-1:0];

    // Length 0 encodes the maximum payload (1024 DW)
    always_comb begin
        if (!has_data)
            l_eff = '0;
        else if (len_fld == '0)
            l_eff = LW'(1) << PAYLOAD_LENGTH;
        else
            l_eff = {1'b0, len_fld};
    end

    assign need    = ({1'b0, l_eff} + (LW+1)'(7)) >> 3;
    assign rem_dec = (rem_dw > LW'(NUM_DW)) ? rem_dw - LW'(NUM_DW) : '0;

    function automatic logic [DATA_WIDTH-1:0] mask_dw(input logic [DATA_WIDTH-1:0] d,
                                                      input logic [LW-1:0] n);
        logic [DATA_WIDTH-1:0] m;
        m = d;
        for (int i = 0; i < NUM_DW; i++)
            if (LW'(i) >= n) m[i*32 +: 32] = '0;
        return m;
    endfunction

    function automatic logic [CCW-1:0] cap_carry(input logic [LW-1:0] n);
        return (n > LW'(CARRY_DW)) ? CCW'(CARRY_DW) : CCW'(n);
    endfunction

    always_comb begin
        state_nxt      = state;
        o_tlp_ready    = 1'b0;
        o_hdr_wr_en    = 1'b0;
        o_hdr_wr_data  = '0;
        o_data_wr_en   = 1'b0;
        o_data_wr_data = '0;
        o_malformed    = 1'b0;
        sop_take       = 1'b0;
        beat_take      = 1'b0;
        case (state)
            IDLE: begin
                // Space is reserved for the whole TLP up front; nothing stalls it afterwards
                o_tlp_ready = ~i_hdr_full & (32'(i_data_free_entries) >= 32'(need));
                if (i_tlp_valid && o_tlp_ready && i_tlp_sop) begin
                    sop_take = 1'b1;
                    if (l_eff == '0) begin
                        state_nxt = COMMIT;
                    end else if (i_tlp_eop) begin
                        state_nxt = FLUSH;
`ifdef CPL_LEN_CHECK_EN
                        o_malformed = (l_eff > LW'(CARRY_DW));
`endif
                    end else begin
                        state_nxt = DATA;
                    end
                end
            end
            DATA: begin
                o_tlp_ready = 1'b1;
                if (i_tlp_valid) begin
`ifdef CPL_LEN_CHECK_EN
                    if (rem_dw == '0) begin
                        o_malformed = 1'b1;
                        if (i_tlp_eop) state_nxt = COMMIT;
                    end else begin
                        beat_take   = 1'b1;
                        o_malformed = i_tlp_eop && (rem_dec > LW'(CARRY_DW));
                    end
`else
                    beat_take = 1'b1;
`endif
                    if (beat_take) begin
                        o_data_wr_en   = 1'b1;
                        o_data_wr_data = mask_dw({i_tlp_data[HDR_WIDTH-1:0], carry_reg}, rem_dw);
                        if (i_tlp_eop) state_nxt = (rem_dec != '0) ? FLUSH : COMMIT;
                    end
                end
            end
            FLUSH: begin
                o_data_wr_en   = 1'b1;
                o_data_wr_data = mask_dw({{HDR_WIDTH{1'b0}}, carry_reg}, LW'(carry_cnt));
                state_nxt      = COMMIT;
            end
            COMMIT: begin
                o_hdr_wr_en   = 1'b1;
                o_hdr_wr_data = hdr_reg;
                state_nxt     = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_n_rst) begin
        if (!i_n_rst) begin
            state     <= IDLE;
            hdr_reg   <= '0;
            carry_reg <= '0;
            rem_dw    <= '0;
            carry_cnt <= '0;
        end else begin
            state <= state_nxt;
            if (sop_take) begin
                hdr_reg   <= i_tlp_data[HDR_WIDTH-1:0];
                carry_reg <= i_tlp_data[DATA_WIDTH-1:HDR_WIDTH];
                rem_dw    <= l_eff;
                carry_cnt <= cap_carry(l_eff);
            end else if (beat_take) begin
                carry_reg <= i_tlp_data[DATA_WIDTH-1:HDR_WIDTH];
                rem_dw    <= rem_dec;
                carry_cnt <= cap_carry(rem_dec);
            end
        end
    end
endmodule

// File: tb/tb_tl_rx_cpl_write_control.sv
// Bench for tl_rx_cpl_write_control: random TLPs scored against a payload-chunking model.
`timescale 1ns/1ps
module tb_tl_rx_cpl_write_control;
    logic         i_clk = 1'b0;
    logic         i_n_rst = 1'b0;
    logic         i_tlp_valid = 1'b0, i_tlp_sop = 1'b0, i_tlp_eop = 1'b0;
    logic [255:0] i_tlp_data = '0;
    logic         o_tlp_ready;
    logic         i_hdr_full = 1'b0;
    logic [7:0]   i_data_free_entries = 8'd255;
    logic         o_hdr_wr_en;
    logic [95:0]  o_hdr_wr_data;
    logic         o_data_wr_en;
    logic [255:0] o_data_wr_data;
    logic         o_malformed;

    tl_rx_cpl_write_control dut (
        .i_clk(i_clk), .i_n_rst(i_n_rst),
        .i_tlp_valid(i_tlp_valid), .i_tlp_sop(i_tlp_sop), .i_tlp_eop(i_tlp_eop),
        .i_tlp_data(i_tlp_data), .o_tlp_ready(o_tlp_ready),
        .i_hdr_full(i_hdr_full), .i_data_free_entries(i_data_free_entries),
        .o_hdr_wr_en(o_hdr_wr_en), .o_hdr_wr_data(o_hdr_wr_data),
        .o_data_wr_en(o_data_wr_en), .o_data_wr_data(o_data_wr_data),
        .o_malformed(o_malformed)
    );

    always #5 i_clk = ~i_clk;

    typedef struct { logic [255:0] d; bit sop; bit eop; } beat_t;

    int checks = 0, errors = 0;
    int cyc = 0;
    beat_t        beat_q[$];
    logic [255:0] exp_data_q[$];
    logic [95:0]  exp_hdr_q[$];
    bit           exp_nodata_q[$];
    int           sop_cyc_q[$];
    int n_data, n_hdr, n_mal, n_sop, exp_need_total;
    int last_data_cyc, last_hdr_cyc;
    bit strict;
    logic [255:0] mon_d;
    logic [95:0]  mon_h;
    bit           mon_nd;
    int           mon_sc, mon_want;

    always @(posedge i_clk) cyc++;

    // Scoreboard: every write is matched against the model queues as it happens
    always @(negedge i_clk) begin
        if (i_n_rst) begin
            if (o_data_wr_en) begin
                n_data++;
                last_data_cyc = cyc;
                if (strict) begin
                    checks++;
                    if (exp_data_q.size() == 0) begin
                        errors++;
                        $display("FAIL data_extra: got unexpected entry %h", o_data_wr_data);
                    end else begin
                        mon_d = exp_data_q.pop_front();
                        if (o_data_wr_data !== mon_d) begin
                            errors++;
                            $display("FAIL data_entry: got %h want %h", o_data_wr_data, mon_d);
                        end
                    end
                end
            end
            if (o_hdr_wr_en) begin
                n_hdr++;
                checks++;
                if (exp_hdr_q.size() == 0 || sop_cyc_q.size() == 0) begin
                    errors++;
                    $display("FAIL hdr_extra: got unexpected header %h", o_hdr_wr_data);
                end else begin
                    mon_h  = exp_hdr_q.pop_front();
                    mon_nd = exp_nodata_q.pop_front();
                    mon_sc = sop_cyc_q.pop_front();
                    if (o_hdr_wr_data !== mon_h) begin
                        errors++;
                        $display("FAIL hdr_data: got %h want %h", o_hdr_wr_data, mon_h);
                    end
                    if (strict) begin
                        checks++;
                        mon_want = mon_nd ? mon_sc + 1 : last_data_cyc + 1;
                        if (cyc != mon_want) begin
                            errors++;
                            $display("FAIL hdr_latency: got cycle %0d want %0d", cyc, mon_want);
                        end
                    end
                end
                last_hdr_cyc = cyc;
            end
            if (o_malformed) n_mal++;
        end
    end

    task automatic clear_sb();
        beat_q.delete(); exp_data_q.delete(); exp_hdr_q.delete();
        exp_nodata_q.delete(); sop_cyc_q.delete();
        n_data = 0; n_hdr = 0; n_mal = 0; n_sop = 0; exp_need_total = 0;
        last_data_cyc = -10; last_hdr_cyc = -10; strict = 1;
    endtask

    // Model: payload is a flat DW list; entries are 8-DW chunks of it, zero padded
    task automatic build(input bit fmt, input int len, input int nb_ovr);
        int leff, nb, idx, need;
        logic [31:0] p[$];
        logic [31:0] h[3];
        logic [255:0] d;
        beat_t b;
        leff = !fmt ? 0 : (len == 0 ? 1024 : len);
        for (int i = 0; i < leff; i++) p.push_back($urandom);
        for (int i = 0; i < 3; i++) h[i] = $urandom;
        h[0][30] = fmt;
        h[0][9:0] = len[9:0];
        nb = (leff > 5) ? 1 + (leff - 5 + 7) / 8 : 1;
        if (nb_ovr > 0) nb = nb_ovr;
        idx = 0;
        for (int bi = 0; bi < nb; bi++) begin
            for (int j = 0; j < 8; j++) begin
                if (bi == 0 && j < 3) d[j*32 +: 32] = h[j];
                else if (idx < leff) begin d[j*32 +: 32] = p[idx]; idx++; end
                else d[j*32 +: 32] = $urandom;
            end
            b.d = d; b.sop = (bi == 0); b.eop = (bi == nb - 1);
            beat_q.push_back(b);
        end
        need = (leff + 7) / 8;
        for (int k = 0; k < need; k++) begin
            for (int j = 0; j < 8; j++)
                d[j*32 +: 32] = (8*k + j < leff) ? p[8*k + j] : 32'h0;
            exp_data_q.push_back(d);
        end
        exp_hdr_q.push_back({h[2], h[1], h[0]});
        exp_nodata_q.push_back(leff == 0);
        exp_need_total += need;
    endtask

    task automatic drive_beats(input int n);
        beat_t b;
        int k;
        for (int i = 0; i < n && beat_q.size() > 0; i++) begin
            b = beat_q.pop_front();
            i_tlp_valid = 1'b1; i_tlp_sop = b.sop; i_tlp_eop = b.eop; i_tlp_data = b.d;
            k = 0;
            @(negedge i_clk);
            if (!b.sop) begin
                checks++;
                if (o_tlp_ready !== 1'b1) begin
                    errors++;
                    $display("FAIL mid_tlp_ready: got %b want 1", o_tlp_ready);
                end
            end
            while (o_tlp_ready !== 1'b1 && k < 200) begin @(negedge i_clk); k++; end
            if (k >= 200) begin
                checks++; errors++;
                $display("FAIL ready_timeout: ready stayed %b, want 1", o_tlp_ready);
                i_tlp_valid = 1'b0;
                return;
            end
            if (b.sop) begin
                checks++;
                if (n_hdr != n_sop || last_hdr_cyc >= cyc) begin
                    errors++;
                    $display("FAIL sop_before_commit: headers %0d want %0d, last hdr cycle %0d vs sop %0d",
                             n_hdr, n_sop, last_hdr_cyc, cyc);
                end
                n_sop++;
                sop_cyc_q.push_back(cyc);
            end
            @(posedge i_clk); #1;
            i_tlp_valid = 1'b0; i_tlp_sop = 1'b0; i_tlp_eop = 1'b0;
            if ($urandom_range(0, 3) == 0) begin @(posedge i_clk); #1; end
        end
    endtask

    task automatic wait_done();
        int k = 0;
        while (exp_hdr_q.size() > 0 && k < 400) begin @(negedge i_clk); k++; end
        checks++;
        if (exp_hdr_q.size() > 0) begin
            errors++;
            $display("FAIL commit_timeout: %0d headers outstanding, want 0", exp_hdr_q.size());
        end
        repeat (3) @(negedge i_clk);
        @(posedge i_clk); #1;
    endtask

    task automatic test_reset();
        i_n_rst = 1'b0;
        repeat (2) @(negedge i_clk);
        checks++;
        if ({o_tlp_ready, o_hdr_wr_en, o_data_wr_en, o_malformed} !== 4'b1000 ||
            o_hdr_wr_data !== '0 || o_data_wr_data !== '0) begin
            errors++;
            $display("FAIL reset_outputs: rdy/hwe/dwe/mal=%b want 1000", {o_tlp_ready, o_hdr_wr_en, o_data_wr_en, o_malformed});
        end
        i_n_rst = 1'b1;
        repeat (2) @(negedge i_clk);
        checks++;
        if ({o_tlp_ready, o_hdr_wr_en, o_data_wr_en} !== 3'b100) begin
            errors++;
            $display("FAIL idle_outputs: rdy/hwe/dwe=%b want 100", {o_tlp_ready, o_hdr_wr_en, o_data_wr_en});
        end
        @(posedge i_clk); #1;
    endtask

    task automatic test_no_data();
        clear_sb();
        build(1'b0, int'($urandom_range(0, 1023)), 0);
        drive_beats(1);
        wait_done();
        checks++;
        if (n_data != 0 || n_hdr != 1) begin
            errors++;
            $display("FAIL no_data_counts: data %0d hdr %0d want 0 1", n_data, n_hdr);
        end
    endtask

    task automatic test_len4();
        clear_sb();
        build(1'b1, 4, 0);
        drive_beats(1);
        wait_done();
        checks++;
        if (n_data != 1 || n_hdr != 1) begin
            errors++;
            $display("FAIL len4_counts: data %0d hdr %0d want 1 1", n_data, n_hdr);
        end
    endtask

    task automatic test_len13();
        clear_sb();
        build(1'b1, 13, 0);
        i_data_free_entries = 8'd1;
        i_tlp_valid = 1'b1; i_tlp_sop = 1'b1; i_tlp_eop = 1'b0; i_tlp_data = beat_q[0].d;
        @(negedge i_clk);
        checks++;
        if (o_tlp_ready !== 1'b0) begin errors++; $display("FAIL len13_space_short: ready %b want 0", o_tlp_ready); end
        i_data_free_entries = 8'd2; i_hdr_full = 1'b1; #1;
        checks++;
        if (o_tlp_ready !== 1'b0) begin errors++; $display("FAIL hdr_full_block: ready %b want 0", o_tlp_ready); end
        i_hdr_full = 1'b0; #1;
        checks++;
        if (o_tlp_ready !== 1'b1) begin errors++; $display("FAIL len13_space_exact: ready %b want 1", o_tlp_ready); end
        i_tlp_valid = 1'b0;
        @(posedge i_clk); #1;
        drive_beats(2);
        wait_done();
        checks++;
        if (n_data != 2 || n_hdr != 1 || n_mal != 0) begin
            errors++;
            $display("FAIL len13_counts: data %0d hdr %0d mal %0d want 2 1 0", n_data, n_hdr, n_mal);
        end
        i_data_free_entries = 8'd255;
    endtask

    task automatic test_len1024();
        clear_sb();
        build(1'b1, 0, 0);
        i_data_free_entries = 8'd127;
        i_tlp_valid = 1'b1; i_tlp_sop = 1'b1; i_tlp_eop = 1'b0; i_tlp_data = beat_q[0].d;
        repeat (3) @(negedge i_clk);
        checks++;
        if (o_tlp_ready !== 1'b0 || n_data != 0) begin
            errors++;
            $display("FAIL len1024_free127: ready %b writes %0d want 0 0", o_tlp_ready, n_data);
        end
        i_data_free_entries = 8'd128; #1;
        checks++;
        if (o_tlp_ready !== 1'b1) begin errors++; $display("FAIL len1024_free128: ready %b want 1", o_tlp_ready); end
        i_tlp_valid = 1'b0;
        @(posedge i_clk); #1;
        drive_beats(1000);
        wait_done();
        checks++;
        if (n_data != 128 || n_hdr != 1) begin
            errors++;
            $display("FAIL len1024_counts: data %0d hdr %0d want 128 1", n_data, n_hdr);
        end
        i_data_free_entries = 8'd255;
    endtask

    task automatic test_back_to_back();
        clear_sb();
        build(1'b1, 20, 0);
        build(1'b0, 7, 0);
        build(1'b1, 3, 0);
        build(1'b1, 8, 0);
        drive_beats(1000);
        wait_done();
        checks++;
        if (n_data != exp_need_total || n_hdr != 4) begin
            errors++;
            $display("FAIL b2b_counts: data %0d hdr %0d want %0d 4", n_data, n_hdr, exp_need_total);
        end
    endtask

    task automatic test_random();
        clear_sb();
        i_data_free_entries = 8'(128 + $urandom_range(0, 127));
        for (int t = 0; t < 24; t++)
            build($urandom_range(0, 3) != 0,
                  ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 1023)) : int'($urandom_range(1, 40)), 0);
        drive_beats(100000);
        wait_done();
        checks++;
        if (n_data != exp_need_total || n_hdr != 24 || n_mal != 0) begin
            errors++;
            $display("FAIL random_counts: data %0d hdr %0d mal %0d want %0d 24 0", n_data, n_hdr, n_mal, exp_need_total);
        end
        i_data_free_entries = 8'd255;
    endtask

    task automatic test_reset_mid();
        clear_sb();
        build(1'b1, 40, 0);
        drive_beats(2);
        checks++;
        if (n_hdr != 0 || n_data != 1) begin
            errors++;
            $display("FAIL partial_before_reset: hdr %0d data %0d want 0 1", n_hdr, n_data);
        end
        #2 i_n_rst = 1'b0;
        @(negedge i_clk);
        i_n_rst = 1'b1;
        clear_sb();
        @(posedge i_clk); #1;
        build(1'b1, 9, 0);
        drive_beats(10);
        wait_done();
        checks++;
        if (n_data != 2 || n_hdr != 1) begin
            errors++;
            $display("FAIL after_reset_counts: data %0d hdr %0d want 2 1", n_data, n_hdr);
        end
    endtask

`ifdef CPL_LEN_CHECK_EN
    task automatic test_malformed();
        clear_sb();
        strict = 0;
        build(1'b1, 16, 2);
        drive_beats(2);
        wait_done();
        checks++;
        if (n_mal != 1 || n_hdr != 1 || n_data != 2) begin
            errors++;
            $display("FAIL short_eop: mal %0d hdr %0d data %0d want 1 1 2", n_mal, n_hdr, n_data);
        end
        clear_sb();
        strict = 0;
        build(1'b1, 3, 3);
        drive_beats(3);
        wait_done();
        checks++;
        if (n_mal != 1 || n_hdr != 1 || n_data != 1) begin
            errors++;
            $display("FAIL extra_beat: mal %0d hdr %0d data %0d want 1 1 1", n_mal, n_hdr, n_data);
        end
    endtask
`endif

    initial begin
        clear_sb();
        test_reset();
        test_no_data();
        test_len4();
        test_len13();
        test_len1024();
        test_back_to_back();
        test_random();
        test_reset_mid();
`ifdef CPL_LEN_CHECK_EN
        test_malformed();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "watchdog expired");
    end
endmodule
